// File: rtl/hybrid_pkg.sv
// rtl/hybrid_pkg.sv - shared state encoding and default timing constants for the hybrid controller
package hybrid_pkg;

    localparam int DEAD_TIME_DEF = 50;
    localparam int MIN_ON_DEF    = 100;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        DT_TO_H = 3'd1,
        H_ON    = 3'd2,
        DT_TO_L = 3'd3,
        L_ON    = 3'd4
    } state_e;

endpackage

// File: rtl/dead_time_gate_driver_if.sv
// rtl/dead_time_gate_driver_if.sv - sigma/enable inputs and gate/debug outputs of the gate driver
interface dead_time_gate_driver_if
    import hybrid_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             i_enable;
    logic             i_sigma;
    logic             o_gate_H;
    logic             o_gate_L;
    logic             o_sigma_applied;
    logic [CNT_W-1:0] o_switch_count;
    logic [2:0]       o_state;

    modport master (
        output i_enable, i_sigma,
        input  o_gate_H, o_gate_L, o_sigma_applied, o_switch_count, o_state
    );

    modport slave (
        input  i_enable, i_sigma,
        output o_gate_H, o_gate_L, o_sigma_applied, o_switch_count, o_state
    );
endinterface

// File: rtl/sigma_sync.sv
// rtl/sigma_sync.sv - two-flop synchroniser bringing sigma in from an asynchronous source
module sigma_sync (
    input  logic i_clock,
    input  logic i_RESET,
    input  logic sigma_i,
    output logic sigma_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= sigma_i;
            sync_q <= meta_q;
        end
    end

    assign sigma_o = sync_q;
endmodule

// File: rtl/dead_time_gate_driver.sv
// rtl/dead_time_gate_driver.sv - complementary gate driver with dead time and minimum on-time
// Optional: define SIGMA_SYNC_EN to pass i_sigma through a two-flop synchroniser first.
module dead_time_gate_driver
    import hybrid_pkg::*;
#(
    parameter int DEAD_TIME = DEAD_TIME_DEF,
    parameter int MIN_ON    = MIN_ON_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_RESET,
    dead_time_gate_driver_if.slave  bus
);
    if (DEAD_TIME < 1) begin : g_bad_dead_time
        $error("DEAD_TIME must be >= 1");
    end
    if (MIN_ON < 1) begin : g_bad_min_on
        $error("MIN_ON must be >= 1");
    end
    if (((64'd1 << CNT_W) <= 64'(DEAD_TIME)) || ((64'd1 << CNT_W) <= 64'(MIN_ON))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEAD_TIME/MIN_ON");
    end

    localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sigma_s;

`ifdef SIGMA_SYNC_EN
    sigma_sync u_sigma_sync (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .sigma_i (bus.i_sigma),
        .sigma_o (sigma_s)
    );
`else
    assign sigma_s = bus.i_sigma;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] count_q;
    logic             gate_h_q;
    logic             gate_l_q;
    logic             applied_q;

    // Gates are only ever set on entry to an ON state and cleared on leaving it,
    // so both-high cannot occur even transiently.
    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            state_q   <= OFF;
            timer_q   <= '0;
            count_q   <= '0;
            gate_h_q  <= 1'b0;
            gate_l_q  <= 1'b0;
            applied_q <= 1'b0;
        end else if (!bus.i_enable) begin
            state_q  <= OFF;
            timer_q  <= '0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_q  <= sigma_s ? DT_TO_H : DT_TO_L;
                    timer_q  <= '0;
                    gate_h_q <= 1'b0;
                    gate_l_q <= 1'b0;
                end
                DT_TO_H: begin
                    if (timer_q == DT_LAST) begin
                        state_q   <= H_ON;
                        timer_q   <= '0;
                        gate_h_q  <= 1'b1;
                        applied_q <= 1'b1;
                        count_q   <= count_q + CNT_ONE;
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                DT_TO_L: begin
                    if (timer_q == DT_LAST) begin
                        state_q   <= L_ON;
                        timer_q   <= '0;
                        gate_l_q  <= 1'b1;
                        applied_q <= 1'b0;
                        count_q   <= count_q + CNT_ONE;
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                // A request before MIN_ON is not latched; it simply wins once the timer saturates.
                H_ON: begin
                    if (!sigma_s && timer_q == ON_LAST) begin
                        state_q  <= DT_TO_L;
                        timer_q  <= '0;
                        gate_h_q <= 1'b0;
                    end else if (timer_q != ON_LAST) begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                L_ON: begin
                    if (sigma_s && timer_q == ON_LAST) begin
                        state_q  <= DT_TO_H;
                        timer_q  <= '0;
                        gate_l_q <= 1'b0;
                    end else if (timer_q != ON_LAST) begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q  <= OFF;
                    timer_q  <= '0;
                    gate_h_q <= 1'b0;
                    gate_l_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_gate_H        = gate_h_q;
    assign bus.o_gate_L        = gate_l_q;
    assign bus.o_sigma_applied = applied_q;
    assign bus.o_switch_count  = count_q;
    assign bus.o_state         = state_q;
endmodule

// File: tb/tb_dead_time_gate_driver.sv
// tb/tb_dead_time_gate_driver.sv - directed self-checking bench for dead_time_gate_driver
module tb_dead_time_gate_driver;
    localparam int DT  = 4;
`ifdef SIGMA_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst_n;
    logic enable;
    logic sigma;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   chk_on   = 0;
    int   low_run  = 8;
    logic prev_h   = 1'b0;
    logic prev_l   = 1'b0;

    dead_time_gate_driver_if #(.CNT_W(16)) u_bus  ();
    dead_time_gate_driver_if #(.CNT_W(4))  u_bus4 ();

    assign u_bus.i_enable  = enable;
    assign u_bus.i_sigma   = sigma;
    assign u_bus4.i_enable = enable;
    assign u_bus4.i_sigma  = sigma;

    dead_time_gate_driver #(.DEAD_TIME(DT), .MIN_ON(10), .CNT_W(16)) u_dut (
        .i_clock (clk),
        .i_RESET (rst_n),
        .bus     (u_bus)
    );

    dead_time_gate_driver #(.DEAD_TIME(DT), .MIN_ON(10), .CNT_W(4)) u_dut4 (
        .i_clock (clk),
        .i_RESET (rst_n),
        .bus     (u_bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input int st, input int gh, input int gl);
        chk({tag, "_state"}, 32'(u_bus.o_state), st);
        chk({tag, "_gate_H"}, 32'(u_bus.o_gate_H), gh);
        chk({tag, "_gate_L"}, 32'(u_bus.o_gate_L), gl);
    endtask

    // Invariants over the whole run: never both gates on, and every rising gate
    // preceded by at least DT cycles with both gates off.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("both_high", 32'(u_bus.o_gate_H & u_bus.o_gate_L), 0);
            if ((u_bus.o_gate_H && !prev_h) || (u_bus.o_gate_L && !prev_l))
                chk("dead_time_gap", 32'(low_run >= DT), 1);
            low_run = (!u_bus.o_gate_H && !u_bus.o_gate_L) ? low_run + 1 : 0;
            prev_h  = u_bus.o_gate_H;
            prev_l  = u_bus.o_gate_L;
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; sigma = 1'b0;
        tick(2);
        chk_main("reset", 0, 0, 0);
        chk("reset_count", 32'(u_bus.o_switch_count), 0);
        chk("reset_applied", 32'(u_bus.o_sigma_applied), 0);
        chk_on = 1;

        rst_n = 1'b1; sigma = 1'b1;
        tick(3);
        chk_main("idle_disabled", 0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick(1);
            chk_main("first_dt", 1, 0, 0);
        end
        tick(1);
        chk_main("first_h_on", 2, 1, 0);
        chk("first_count", 32'(u_bus.o_switch_count), 1);
        chk("first_applied", 32'(u_bus.o_sigma_applied), 1);

        tick(12);
        chk_main("steady_h", 2, 1, 0);
        sigma = 1'b0;
        tick(1 + LAT);
        chk_main("h_fall", 3, 0, 0);
        tick(DT - 1);
        chk_main("dt_to_l_end", 3, 0, 0);
        tick(1);
        chk_main("l_rise", 4, 0, 1);
        chk("count_2", 32'(u_bus.o_switch_count), 2);
        chk("applied_0", 32'(u_bus.o_sigma_applied), 0);

        tick(2);
        sigma = 1'b1;
        tick(7);
        chk_main("deferred_hold", 4, 0, 1);
        tick(1);
        chk_main("deferred_start", 1, 0, 0);
        tick(DT);
        chk_main("deferred_h_on", 2, 1, 0);
        chk("count_3", 32'(u_bus.o_switch_count), 3);

        tick(2);
        sigma = 1'b0;
        tick(1);
        sigma = 1'b1;
        tick(9);
        chk_main("glitch_ignored", 2, 1, 0);
        chk("glitch_count", 32'(u_bus.o_switch_count), 3);

        enable = 1'b0;
        tick(1);
        chk_main("disable_on", 0, 0, 0);
        enable = 1'b1;
        tick(1);
        chk_main("reenable_dt", 1, 0, 0);
        tick(DT - 1);
        chk_main("reenable_dt_end", 1, 0, 0);
        tick(1);
        chk_main("reenable_h", 2, 1, 0);
        chk("count_4", 32'(u_bus.o_switch_count), 4);

        tick(10);
        sigma = 1'b0;
        tick(1 + LAT);
        chk_main("h_fall2", 3, 0, 0);
        tick(2);
        enable = 1'b0;
        tick(1);
        chk_main("disable_dt", 0, 0, 0);
        enable = 1'b1;
        tick(1);
        chk_main("reenable_dt_l", 3, 0, 0);
        tick(DT - 1);
        chk_main("reenable_dt_l_end", 3, 0, 0);
        tick(1);
        chk_main("reenable_l", 4, 0, 1);
        chk("count_5", 32'(u_bus.o_switch_count), 5);

        rst_n = 1'b0; enable = 1'b0;
        tick(1);
        chk_main("reset_mid_on", 0, 0, 0);
        chk("reset_mid_count", 32'(u_bus.o_switch_count), 0);

        rst_n = 1'b1; sigma = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(DT + 1);
        chk("wrap_first_state", 32'(u_bus4.o_state), 2);
        tick(11);
        for (int i = 0; i < 14; i++) begin
            sigma = ~sigma;
            tick(16 + LAT);
        end
        chk("wrap_pre_state", 32'(u_bus4.o_state), 2);
        chk("wrap_pre_count4", 32'(u_bus4.o_switch_count), 15);
        chk("wrap_pre_count16", 32'(u_bus.o_switch_count), 15);
        sigma = ~sigma;
        tick(16 + LAT);
        chk("wrap_state", 32'(u_bus4.o_state), 4);
        chk("wrap_count4", 32'(u_bus4.o_switch_count), 0);
        chk("wrap_count16", 32'(u_bus.o_switch_count), 16);
        for (int i = 0; i < 15; i++) begin
            sigma = ~sigma;
            tick(16 + LAT);
        end
        chk("full_state", 32'(u_bus4.o_state), 2);
        chk("full_count4", 32'(u_bus4.o_switch_count), 15);
        chk("full_count16", 32'(u_bus.o_switch_count), 31);

        rst_n = 1'b0; enable = 1'b0;
        tick(1);
        chk("rst_full_state", 32'(u_bus4.o_state), 0);
        chk("rst_full_gate_H", 32'(u_bus4.o_gate_H), 0);
        chk("rst_full_gate_L", 32'(u_bus4.o_gate_L), 0);
        chk("rst_full_applied", 32'(u_bus4.o_sigma_applied), 0);
        chk("rst_full_count", 32'(u_bus4.o_switch_count), 0);

        rst_n = 1'b1;
        tick(3);
        enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            sigma = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 20));
        end
        chk("random_state_legal", 32'(u_bus.o_state <= 3'd4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
